// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor: resolves one SEG_W-bit segment per
// cycle (LSB first) with 4-bit lookahead groups; the inter-segment carry is registered.
module cla_seq_adder #(
   parameter int WIDTH = 64,
   parameter int SEG_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG  = WIDTH / SEG_W;
   localparam int NGRP  = SEG_W / 4;
   localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic               carry_reg;
   logic [CNT_W-1:0]   cnt;

   logic [SEG_W-1:0]   seg_a;
   logic [SEG_W-1:0]   seg_b;
   logic [SEG_W-1:0]   seg_sum;
   logic [SEG_W:0]     seg_carry;
   logic [4:0]         grp_carry;
   logic               chain;
   int                 seg_base;

   // Carries into bits 0..3 and out of bit 3 of one group, in lookahead form.
   function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic c0);
      logic [4:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

   // Resolve the current segment by chaining lookahead groups from the registered carry.
   always_comb begin
      seg_base  = int'(cnt) * SEG_W;
      seg_a     = a_reg[seg_base +: SEG_W];
      seg_b     = b_reg[seg_base +: SEG_W];
      seg_sum   = '0;
      seg_carry = '0;
      grp_carry = '0;
      chain     = carry_reg;
      for (int i = 0; i < NGRP; i++) begin
         grp_carry = cla4(seg_a[i*4 +: 4] ^ seg_b[i*4 +: 4],
                          seg_a[i*4 +: 4] & seg_b[i*4 +: 4], chain);
         seg_carry[i*4 +: 4] = grp_carry[3:0];
         seg_sum[i*4 +: 4]   = seg_a[i*4 +: 4] ^ seg_b[i*4 +: 4] ^ grp_carry[3:0];
         chain               = grp_carry[4];
      end
      seg_carry[SEG_W] = chain;
   end

   // Handshake FSM, operand latch and segment-by-segment result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         cnt       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= sub ? ~b : b;
                  carry_reg <= sub ? 1'b1 : cin;
                  cnt       <= '0;
                  in_ready  <= 1'b0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               sum[seg_base +: SEG_W] <= seg_sum;
               carry_reg              <= seg_carry[SEG_W];
               cnt                    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(NSEG - 1)) begin
                  cout      <= seg_carry[SEG_W];
                  // carry into the MSB differs from carry out of it on signed overflow
                  ovf       <= seg_carry[SEG_W-1] ^ seg_carry[SEG_W];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference adder.
module tb_cla_seq_adder;

   localparam int WIDTH = 64;
   localparam int NSEG  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             sub = 1'b0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] exp_sum;
   logic             exp_cout;
   logic             exp_ovf;

   cla_seq_adder #(.WIDTH(WIDTH), .SEG_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #50_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, want);
      end
   endtask

   // Reference: wide integer addition of a, effective b and carry-in.
   task automatic ref_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic ts, input logic tc);
      logic [WIDTH-1:0] be;
      logic [WIDTH:0]   t;
      be = ts ? ~tb_v : tb_v;
      t  = {1'b0, ta} + {1'b0, be} + {{WIDTH{1'b0}}, (ts ? 1'b1 : tc)};
      exp_sum  = t[WIDTH-1:0];
      exp_cout = t[WIDTH];
      exp_ovf  = (ta[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != ta[WIDTH-1]);
   endtask

   task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic ts, input logic tc);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", {63'd0, in_ready}, 64'd1);
      a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
      ref_add(ta, tb_v, ts, tc);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit noise);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check("latency", 64'(lat), 64'(NSEG));
   endtask

   task automatic result(input string tag, input logic [WIDTH-1:0] s,
                         input logic c, input logic o);
      check({tag, "_sum"}, sum, s);
      check({tag, "_cout"}, {63'd0, cout}, {63'd0, c});
      check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, o});
   endtask

   task automatic release_result(input int hold, input bit noise);
      for (int i = 0; i < hold; i++) begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
         end
         @(negedge clk);
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_sum", sum, exp_sum);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", {63'd0, out_valid}, 64'd0);
      check("release_ready", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      bit seen_valid;

      repeat (2) @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_sum", sum, 64'd0);
      check("rst_cout", {63'd0, cout}, 64'd0);
      check("rst_ovf", {63'd0, ovf}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      wait_done(1'b0);
      result("ripple", 64'd0, 1'b1, 1'b0);
      release_result(0, 1'b0);

      send(64'd0, 64'd0, 1'b0, 1'b1);
      wait_done(1'b0);
      result("cin_only", 64'd1, 1'b0, 1'b0);
      release_result(0, 1'b0);

      send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      wait_done(1'b0);
      result("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      release_result(0, 1'b0);

      send(64'd5, 64'd7, 1'b1, 1'b1);
      wait_done(1'b0);
      result("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      release_result(0, 1'b0);

      send(64'd7, 64'd5, 1'b1, 1'b0);
      wait_done(1'b0);
      result("sub_noborrow", 64'd2, 1'b1, 1'b0);
      release_result(0, 1'b0);

      send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
      wait_done(1'b0);
      result("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // Stall in DONE with new operands offered; they must wait for IDLE.
      a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111; sub = 1'b0; cin = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", {63'd0, out_valid}, 64'd1);
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
         check("stall_sum", sum, 64'h7FFF_FFFF_FFFF_FFFF);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("drain_valid", {63'd0, out_valid}, 64'd0);
      check("drain_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("late_accept", {63'd0, in_ready}, 64'd0);
      wait_done(1'b0);
      result("late_op", 64'h1234_5678_9ABC_DF01, 1'b0, 1'b0);
      release_result(0, 1'b0);

      // Reset in the second BUSY cycle aborts the operation silently.
      send(64'd3, 64'd4, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", {63'd0, in_ready}, 64'd1);
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_sum", sum, 64'd0);
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      check("abort_no_valid", {63'd0, seen_valid}, 64'd0);

      for (int n = 0; n < 10000; n++) begin
         send({$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         wait_done(1'b1);
         result("rand", exp_sum, exp_cout, exp_ovf);
         release_result(($urandom_range(0, 3) == 0) ? 1 : 0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
